// File: rtl/scv_audio_out_if.sv
// Audio back-end bus: APU PCM strobe and mute in, decimated signed sample out.
interface scv_audio_out_if;
  logic               AUD_CE;
  logic [8:0]         AUD_PCM;
  logic               MUTE;
  logic signed [15:0] AUD_OUT;
  logic               AUD_VALID;

  modport master (output AUD_CE, AUD_PCM, MUTE, input AUD_OUT, AUD_VALID);
  modport slave  (input AUD_CE, AUD_PCM, MUTE, output AUD_OUT, AUD_VALID);
endinterface

// File: rtl/scv_audio_out.sv
// Box-car decimator (6 MHz -> 48 kHz) with re-centring to signed 16-bit and an
// optional one-pole DC-blocking high-pass on the decimated stream.
module scv_audio_out #(
  parameter bit          DC_BLOCK = 1'b1,
  parameter int unsigned DECIM    = 125
) (
  input  logic           CLK,
  input  logic           RESB,
  scv_audio_out_if.slave aud
);
  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned Y_W   = 19;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [ACC_W:0] X_OFFSET = 17'sd32000;
  localparam logic signed [Y_W-1:0] Y_MAX    = 19'sd32767;
  localparam logic signed [Y_W-1:0] Y_MIN    = -19'sd32768;

  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;
  logic                    v1;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] xp;
  logic signed [ACC_W-1:0] yp;

  logic                    sample_edge_c;
  logic [ACC_W-1:0]        acc_sum_c;
  logic signed [ACC_W:0]   x_wide_c;
  logic signed [Y_W-1:0]   y_wide_c;
  logic signed [ACC_W-1:0] y_sat_c;
  logic signed [ACC_W-1:0] y_sel_c;

  // Stage 1: window accumulation; the closing PCM value belongs to this window.
  always_comb begin
    sample_edge_c = aud.AUD_CE && (cnt == CNT_LAST);
    acc_sum_c     = acc + ACC_W'(aud.AUD_PCM);
    x_wide_c      = $signed({1'b0, acc_sum_c}) - X_OFFSET;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      acc <= '0;
      cnt <= '0;
      v1  <= 1'b0;
      x   <= '0;
    end else begin
      v1 <= sample_edge_c;
      if (sample_edge_c) begin
        x   <= x_wide_c[ACC_W-1:0];
        acc <= '0;
        cnt <= '0;
      end else if (aud.AUD_CE) begin
        acc <= acc_sum_c;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: y = x - xp + yp - (yp >>> 8) at 19 bits, saturated back to 16.
  always_comb begin
    y_wide_c = Y_W'(x) - Y_W'(xp) + Y_W'(yp) - Y_W'(yp >>> 8);
    if (y_wide_c > Y_MAX) begin
      y_sat_c = 16'sh7FFF;
    end else if (y_wide_c < Y_MIN) begin
      y_sat_c = -16'sh8000;
    end else begin
      y_sat_c = y_wide_c[ACC_W-1:0];
    end
    y_sel_c = DC_BLOCK ? y_sat_c : x;
  end

  // Filter history advances even while muted so unmuting resumes seamlessly.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      xp            <= '0;
      yp            <= '0;
      aud.AUD_OUT   <= '0;
      aud.AUD_VALID <= 1'b0;
    end else begin
      aud.AUD_VALID <= v1;
      if (v1) begin
        xp          <= x;
        yp          <= y_sat_c;
        aud.AUD_OUT <= aud.MUTE ? '0 : y_sel_c;
      end
    end
  end
endmodule
